cardinal_node_nic: RTL and testbench
====================================

# cardinal_node_nic

Network interface controller that sits directly downstream of each Cardinal CPU core in the four-node CMP, between the core's NIC access port and its ring router port. It exposes two single-entry 64-bit packet buffers to the CPU as four memory-mapped registers (input data/status, output data/status). It moves packets to and from the router over a valid/ready link that is gated by the ring's even/odd virtual-channel polarity.

## Interface
Parameters:
- DATA_WIDTH, 64, packet and CPU data width; bit 0 is the MSB, big-endian [0:63] ordering.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  2  CPU register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  in  64  CPU write data.
- d_out  out  64  CPU read data.
- nicEn  in  1  CPU access enable.
- nicWrEn  in  1  CPU write enable; valid only while nicEn=1.
- net_si  in  1  router to NIC packet valid.
- net_ri  out  1  NIC to router ready; the NIC can accept a packet.
- net_di  in  64  router to NIC packet.
- net_so  out  1  NIC to router packet valid.
- net_ro  in  1  router to NIC ready.
- net_do  out  64  NIC to router packet.
- net_polarity  in  1  current router polarity: 0 = even cycle, 1 = odd cycle.

## Operation
- State: in_buf[0:63] and in_full, out_buf[0:63] and out_full.
- Reset sets in_full=0, out_full=0, in_buf=0 and out_buf=0.
  - Output values during reset: d_out=0, net_ri=1, net_so=0, net_do=0.
- CPU reads (nicEn=1, nicWrEn=0) drive d_out combinationally:
  - addr 00 returns in_buf.
  - addr 01 returns {63'b0, in_full}, with in_full at bit 63.
  - addr 10 returns 0.
  - addr 11 returns {63'b0, out_full}.
  - When nicEn=0, or during a write, d_out=0.
- Reading addr 00 while in_full=1 clears in_full at the next edge.
  - Reading addr 00 while in_full=0 returns stale in_buf and has no side effect.
- CPU write to addr 10 while out_full=0 loads d_in into out_buf and sets out_full at the edge.
  - A write to addr 10 while out_full=1 is dropped and out_buf is unchanged.
  - Writes to 00, 01 and 11 are ignored.
- Ingress:
  - net_ri = ~in_full.
  - When net_si=1 and net_ri=1, net_di is captured into in_buf and in_full is set at the edge.
  - net_si while net_ri=0 is a router protocol violation; the NIC ignores it and leaves in_buf unchanged.
- Egress:
  - net_do = out_buf whenever out_full=1, else 0.
  - net_so = out_full & net_ro & (out_buf[0] == net_polarity), where bit 0 is the packet VC bit.
  - When net_so=1, out_full clears at the same edge.
- Simultaneous events:
  - A CPU read of 00 that clears in_full cannot coincide with ingress, because net_ri=0 while the buffer is full.
  - A CPU write to 10 in the same cycle that a send clears out_full is dropped: the full check uses the pre-edge out_full. Software must poll addr 11 before writing.
  - Ingress and egress proceed independently in the same cycle.
- A reset asserted mid-transfer discards both buffers. A packet whose send has not completed is lost.

## Timing
- CPU read latency: 0 cycles (combinational). Status bits reflect register state as of the current cycle.
- Write to send: the earliest net_so is the cycle after the write edge, if polarity matches and net_ro=1.
- Polarity mismatch: the packet waits, and net_so rises in the first cycle where polarity matches and net_ro=1. Polarity toggles every cycle in the ring, so the worst-case extra wait is 1 cycle plus any router back-pressure.
- Receive to CPU: in_full is visible at addr 01 in the cycle after the capture edge.
- Back-to-back ingress is possible: after a CPU read of 00, net_ri=1 in the next cycle.
- Throughput: at most one packet per direction per 2 cycles. This comes from single-entry buffers plus a 1-cycle refill by the CPU.
- There are no combinational paths from net_si or net_di to net_ri, or from d_in to net_so.

## Test plan
- Reset behaviour: hold reset for 3 cycles with random inputs.
  - During reset, net_ri=1, net_so=0, net_do=0 and d_out=0.
  - After release, a read of 01 returns 0 and a read of 11 returns 0.
- Send with matching polarity: write 0x0000_0000_DEAD_BEEF to addr 10 with net_ro=1.
  - In the next cycle, when net_polarity=0, net_so=1 and net_do=0x0000_0000_DEAD_BEEF.
  - One cycle later, a read of 11 returns 0.
- Send with polarity mismatch and back-pressure: write 0x8000_0000_0000_0001 (VC=1), hold net_ro=0 for 4 cycles, then raise net_ro=1.
  - net_so stays 0 until the first cycle with net_polarity=1 and net_ro=1, then pulses for exactly 1 cycle.
- Write while full: with out_full=1 and net_ro=0, write 0x1111 and then 0x2222.
  - After net_ro rises, net_do=0x1111, and exactly one packet is sent.
- Receive: drive net_si=1 with net_di=0x0123_4567_89AB_CDEF.
  - At the next cycle, net_ri=0 and a read of 01 returns 1.
  - A read of 00 returns 0x0123_4567_89AB_CDEF.
  - At the following cycle, net_ri=1 and a read of 01 returns 0.
- Reset mid-operation: load both buffers, then assert reset for 1 cycle.
  - Both status registers read 0, net_so=0, net_ri=1, and no packet is emitted afterwards.

Source files
------------

// File: rtl/cardinal_node_nic.sv
// Cardinal CPU-to-ring NIC: two single-entry 64-bit packet buffers behind four CPU registers.
// CPU reads are combinational; the egress send is held until the VC bit matches ring polarity and the router is ready.
module cardinal_node_nic #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STS  = 2'b01;
  localparam logic [1:0] ADDR_OUT_STS = 2'b11;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;

  logic [0:DATA_WIDTH-1] in_buf;
  logic [0:DATA_WIDTH-1] out_buf;
  logic                  in_full;
  logic                  out_full;

  logic cpu_rd;
  logic cpu_wr;
  logic drain_in;
  logic load_out;
  logic ingress;
  logic egress;

  assign cpu_rd   = nicEn & ~nicWrEn;
  assign cpu_wr   = nicEn & nicWrEn;
  assign drain_in = cpu_rd & (addr == ADDR_IN_BUF) & in_full;
  // Full check uses the pre-edge flag, so a write racing a send is dropped.
  assign load_out = cpu_wr & (addr == ADDR_OUT_BUF) & ~out_full;

  assign ingress = ~reset & net_si & ~in_full;
  assign egress  = ~reset & out_full & net_ro & (out_buf[0] == net_polarity);

  // Outputs are forced to their idle values while reset is held, even before state settles.
  assign net_ri = reset | ~in_full;
  assign net_so = egress;
  assign net_do = (~reset & out_full) ? out_buf : '0;

  always_comb begin
    d_out = '0;
    if (!reset && cpu_rd) begin
      case (addr)
        ADDR_IN_BUF:  d_out = in_buf;
        ADDR_IN_STS:  d_out[DATA_WIDTH-1] = in_full;
        ADDR_OUT_STS: d_out[DATA_WIDTH-1] = out_full;
        default:      d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf   <= '0;
      in_full  <= 1'b0;
      out_buf  <= '0;
      out_full <= 1'b0;
    end else begin
      if (ingress) begin
        in_buf  <= net_di;
        in_full <= 1'b1;
      end else if (drain_in) begin
        in_full <= 1'b0;
      end

      if (egress) begin
        out_full <= 1'b0;
      end else if (load_out) begin
        out_buf  <= d_in;
        out_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cardinal_node_nic.sv
// Directed bench for cardinal_node_nic; ring polarity toggles every cycle as on the real ring.
module tb_cardinal_node_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int tests_run    = 0;
  int tests_failed = 0;

  cardinal_node_nic #(.DATA_WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    net_polarity = ~net_polarity;
  endtask

  task automatic idle();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
    addr    = 2'b00;
    d_in    = '0;
    net_si  = 1'b0;
    net_di  = '0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset   = 1'b1;
      addr    = 2'($urandom_range(0, 3));
      nicEn   = 1'($urandom_range(0, 1));
      nicWrEn = 1'($urandom_range(0, 1));
      d_in    = {$urandom, $urandom};
      net_si  = 1'($urandom_range(0, 1));
      net_di  = {$urandom, $urandom};
      net_ro  = 1'($urandom_range(0, 1));
      #3;
      tests_run++;
      if (net_ri !== 1'b1) begin tests_failed++; $display("FAIL reset_net_ri: got %b expected 1", net_ri); end
      tests_run++;
      if (net_so !== 1'b0) begin tests_failed++; $display("FAIL reset_net_so: got %b expected 0", net_so); end
      tests_run++;
      if (net_do !== 64'h0) begin tests_failed++; $display("FAIL reset_net_do: got %h expected 0", net_do); end
      tests_run++;
      if (d_out !== 64'h0) begin tests_failed++; $display("FAIL reset_d_out: got %h expected 0", d_out); end
      tick();
    end
    reset = 1'b0;
    idle();
    net_ro = 1'b0;
    nicEn = 1'b1; addr = 2'b01;
    #3;
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL post_reset_in_sts: got %h expected 0", d_out); end
    tick();
    addr = 2'b11;
    #3;
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL post_reset_out_sts: got %h expected 0", d_out); end
    tick();
    idle();
  endtask

  task automatic test_send_match();
    if (net_polarity !== 1'b1) tick();
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h0000_0000_DEAD_BEEF;
    net_ro = 1'b1;
    #3;
    tests_run++;
    if (net_so !== 1'b0) begin tests_failed++; $display("FAIL match_write_cycle_so: got %b expected 0", net_so); end
    tick();
    idle();
    #3;
    tests_run++;
    if (net_so !== 1'b1) begin tests_failed++; $display("FAIL match_send_so: got %b expected 1", net_so); end
    tests_run++;
    if (net_do !== 64'h0000_0000_DEAD_BEEF) begin tests_failed++; $display("FAIL match_send_do: got %h expected 00000000deadbeef", net_do); end
    tick();
    nicEn = 1'b1; addr = 2'b11;
    #3;
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL match_out_sts_after: got %h expected 0", d_out); end
    tests_run++;
    if (net_so !== 1'b0) begin tests_failed++; $display("FAIL match_no_resend: got %b expected 0", net_so); end
    tick();
    idle();
  endtask

  task automatic test_send_mismatch();
    logic pending;
    int   sends;
    net_ro = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_0001;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #3;
      tests_run++;
      if (net_so !== 1'b0) begin tests_failed++; $display("FAIL mismatch_backpressure_so: cycle %0d got %b expected 0", i, net_so); end
      tests_run++;
      if (net_do !== 64'h8000_0000_0000_0001) begin tests_failed++; $display("FAIL mismatch_hold_do: got %h expected 8000000000000001", net_do); end
      tick();
    end
    net_ro  = 1'b1;
    pending = 1'b1;
    sends   = 0;
    for (int i = 0; i < 4; i++) begin
      logic exp_so;
      exp_so = pending & net_polarity;
      #3;
      tests_run++;
      if (net_so !== exp_so) begin tests_failed++; $display("FAIL mismatch_so: cycle %0d got %b expected %b", i, net_so, exp_so); end
      if (net_so === 1'b1) sends++;
      if (exp_so) pending = 1'b0;
      tick();
    end
    tests_run++;
    if (sends != 1) begin tests_failed++; $display("FAIL mismatch_send_count: got %0d expected 1", sends); end
  endtask

  task automatic test_write_full();
    logic pending;
    int   sends;
    net_ro = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h1111;
    tick();
    d_in = 64'h2222;
    tick();
    idle();
    nicEn = 1'b1; addr = 2'b11;
    #3;
    tests_run++;
    if (d_out !== 64'h1) begin tests_failed++; $display("FAIL full_out_sts: got %h expected 1", d_out); end
    tests_run++;
    if (net_do !== 64'h1111) begin tests_failed++; $display("FAIL full_kept_first: got %h expected 1111", net_do); end
    tick();
    idle();
    net_ro  = 1'b1;
    pending = 1'b1;
    sends   = 0;
    for (int i = 0; i < 4; i++) begin
      logic exp_so;
      exp_so = pending & ~net_polarity;
      #3;
      tests_run++;
      if (net_so !== exp_so) begin tests_failed++; $display("FAIL full_so: cycle %0d got %b expected %b", i, net_so, exp_so); end
      if (net_so === 1'b1) begin
        sends++;
        tests_run++;
        if (net_do !== 64'h1111) begin tests_failed++; $display("FAIL full_send_do: got %h expected 1111", net_do); end
      end
      if (exp_so) pending = 1'b0;
      tick();
    end
    tests_run++;
    if (sends != 1) begin tests_failed++; $display("FAIL full_send_count: got %0d expected 1", sends); end
    net_ro = 1'b0;
  endtask

  task automatic test_receive();
    net_si = 1'b1; net_di = 64'h0123_4567_89AB_CDEF;
    #3;
    tests_run++;
    if (net_ri !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_empty: got %b expected 1", net_ri); end
    tick();
    idle();
    nicEn = 1'b1; addr = 2'b01;
    #3;
    tests_run++;
    if (net_ri !== 1'b0) begin tests_failed++; $display("FAIL rx_ready_full: got %b expected 0", net_ri); end
    tests_run++;
    if (d_out !== 64'h1) begin tests_failed++; $display("FAIL rx_in_sts_full: got %h expected 1", d_out); end
    tick();
    addr = 2'b00;
    #3;
    tests_run++;
    if (d_out !== 64'h0123_4567_89AB_CDEF) begin tests_failed++; $display("FAIL rx_data: got %h expected 0123456789abcdef", d_out); end
    tick();
    addr = 2'b01;
    net_si = 1'b1; net_di = 64'hAAAA_BBBB_CCCC_DDDD;
    #3;
    tests_run++;
    if (net_ri !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_after_read: got %b expected 1", net_ri); end
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL rx_in_sts_cleared: got %h expected 0", d_out); end
    tick();
    // Buffer is full again; this offer violates protocol and must be ignored.
    addr = 2'b00;
    net_si = 1'b1; net_di = 64'h5555_6666_7777_8888;
    #3;
    tests_run++;
    if (d_out !== 64'hAAAA_BBBB_CCCC_DDDD) begin tests_failed++; $display("FAIL rx_back_to_back: got %h expected aaaabbbbccccdddd", d_out); end
    tick();
    net_si = 1'b0;
    #3;
    tests_run++;
    if (d_out !== 64'hAAAA_BBBB_CCCC_DDDD) begin tests_failed++; $display("FAIL rx_violation_ignored: got %h expected aaaabbbbccccdddd", d_out); end
    tests_run++;
    if (net_ri !== 1'b1) begin tests_failed++; $display("FAIL rx_ready_final: got %b expected 1", net_ri); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    net_ro = 1'b0;
    nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = 64'h42;
    net_si = 1'b1; net_di = 64'h55;
    tick();
    idle();
    nicEn = 1'b1; addr = 2'b11;
    #3;
    tests_run++;
    if (d_out !== 64'h1) begin tests_failed++; $display("FAIL mid_loaded_out: got %h expected 1", d_out); end
    tests_run++;
    if (net_ri !== 1'b0) begin tests_failed++; $display("FAIL mid_loaded_in: got %b expected 0", net_ri); end
    tick();
    idle();
    reset = 1'b1; net_ro = 1'b1;
    #3;
    tests_run++;
    if (net_so !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_so: got %b expected 0", net_so); end
    tick();
    reset = 1'b0;
    nicEn = 1'b1; addr = 2'b01;
    #3;
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL mid_in_sts: got %h expected 0", d_out); end
    tests_run++;
    if (net_ri !== 1'b1) begin tests_failed++; $display("FAIL mid_net_ri: got %b expected 1", net_ri); end
    tick();
    addr = 2'b11;
    #3;
    tests_run++;
    if (d_out !== 64'h0) begin tests_failed++; $display("FAIL mid_out_sts: got %h expected 0", d_out); end
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #3;
      tests_run++;
      if (net_so !== 1'b0) begin tests_failed++; $display("FAIL mid_no_emit: cycle %0d got %b expected 0", i, net_so); end
      tick();
    end
  endtask

  initial begin
    reset        = 1'b1;
    net_polarity = 1'b0;
    net_ro       = 1'b0;
    idle();
    test_reset();
    test_send_match();
    test_send_mismatch();
    test_write_full();
    test_receive();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
